rasterizer_vertex_store: RTL

Avalon-MM write master that builds the vertex buffer consumed by the rasterizer's vertex fetch stage. It accepts whole triangles (15 × 32-bit words) from the geometry stage and writes them back-to-back starting at `vertex_buffer_base + 4`. On flush it writes the triangle count into word 0 at `vertex_buffer_base`, then raises `done_out`.

---
 rtl/rasterizer_pkg.sv | 29 ++
 rtl/rasterizer_vertex_store.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rasterizer_pkg.sv
// Shared vertex-buffer layout constants and the store FSM state type.
// Vertex fetch reads the same layout, so the geometry lives here, not in the writer.
package rasterizer_pkg;

  localparam int ADDR_W         = 26;
  localparam int DATA_W         = 32;
  localparam int WORD_BYTES     = 4;
  localparam int VERTS_PER_TRI  = 3;
  localparam int WORDS_PER_VERT = 5;
  localparam int TRI_WORDS      = VERTS_PER_TRI * WORDS_PER_VERT;
  localparam int TRI_BYTES      = TRI_WORDS * WORD_BYTES;

  // Word 0 of the buffer holds the triangle count; triangle data follows it.
  localparam int COUNT_WORD_OFFSET = 0;
  localparam int FIRST_TRI_OFFSET  = WORD_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE_TRI,
    WRITE_COUNT,
    DONE
  } store_state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rasterizer_vertex_store.sv
// Avalon-MM write master that packs whole triangles into the vertex buffer and,
// on flush, commits the triangle count into word 0 of that buffer.
module rasterizer_vertex_store
  import rasterizer_pkg::*;
#(
  parameter int MAX_TRIS = 1024
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic [ADDR_W-1:0]                   master_address,
  output logic                                master_read,
  output logic                                master_write,
  output logic [3:0]                          master_byteenable,
  output logic [DATA_W-1:0]                   master_writedata,
  input  logic [DATA_W-1:0]                   master_readdata,
  input  logic                                master_readdatavalid,
  input  logic                                master_waitrequest,
  input  logic                                store_enable,
  input  logic [ADDR_W-1:0]                   vertex_buffer_base,
  input  logic                                input_valid,
  input  logic [TRI_WORDS-1:0][DATA_W-1:0]    vertex_in,
  output logic                                stall_out,
  input  logic                                flush_in,
  output logic                                done_out
);

  localparam int CNT_W = $clog2(MAX_TRIS + 1);
  localparam int IDX_W = $clog2(TRI_WORDS);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(TRI_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(MAX_TRIS);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] TRI_START  = ADDR_W'(FIRST_TRI_OFFSET);
  localparam logic [ADDR_W-1:0] COUNT_OFS  = ADDR_W'(COUNT_WORD_OFFSET);

  store_state_t state_q, state_d;

  logic [ADDR_W-1:0]              base_q, base_d;
  logic [ADDR_W-1:0]              next_addr_q, next_addr_d;
  logic [CNT_W-1:0]               tri_count_q, tri_count_d;
  logic [IDX_W-1:0]               w_idx_q, w_idx_d;
  logic [IDX_W-1:0]               w_idx_nx;
  logic                           flush_pend_q, flush_pend_d;
  logic [TRI_WORDS-1:0][DATA_W-1:0] tri_buf;
  logic                           load_buf;

  logic                           write_d;
  logic [ADDR_W-1:0]              address_d;
  logic [DATA_W-1:0]              writedata_d;
  logic                           done_d;

  logic                           full;
  logic                           handshake;
  logic                           unused_read_port;

  assign master_read       = 1'b0;
  assign master_byteenable = 4'b1111;
  assign unused_read_port  = ^{master_readdata, master_readdatavalid};

  assign full      = (tri_count_q == FULL_COUNT);
  assign stall_out = (state_q != ACCEPT) || full || flush_pend_q;
  assign handshake = input_valid && !stall_out;
  assign w_idx_nx  = w_idx_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    next_addr_d  = next_addr_q;
    tri_count_d  = tri_count_q;
    w_idx_d      = w_idx_q;
    flush_pend_d = flush_pend_q;
    load_buf     = 1'b0;
    write_d      = master_write;
    address_d    = master_address;
    writedata_d  = master_writedata;
    done_d       = done_out;

    // A flush is only remembered while a buffer is open; ACCEPT is where it acts.
    if (flush_in && (state_q != IDLE) && (state_q != DONE)) begin
      flush_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (store_enable) begin
          base_d       = word_align(vertex_buffer_base);
          next_addr_d  = word_align(vertex_buffer_base) + TRI_START;
          tri_count_d  = '0;
          flush_pend_d = 1'b0;
          done_d       = 1'b0;
          state_d      = ACCEPT;
        end
      end

      ACCEPT: begin
        if (handshake) begin
          load_buf    = 1'b1;
          w_idx_d     = '0;
          write_d     = 1'b1;
          address_d   = next_addr_q;
          writedata_d = vertex_in[0];
          state_d     = WRITE_TRI;
        end else if (flush_pend_q) begin
          write_d     = 1'b1;
          address_d   = base_q + COUNT_OFS;
          writedata_d = DATA_W'(tri_count_q);
          state_d     = WRITE_COUNT;
        end
      end

      WRITE_TRI: begin
        // Nothing moves while the slave holds waitrequest.
        if (!master_waitrequest) begin
          if (w_idx_q == LAST_IDX) begin
            write_d     = 1'b0;
            next_addr_d = master_address + WORD_STEP;
            tri_count_d = tri_count_q + 1'b1;
            state_d     = ACCEPT;
          end else begin
            w_idx_d     = w_idx_nx;
            address_d   = master_address + WORD_STEP;
            writedata_d = tri_buf[w_idx_nx];
          end
        end
      end

      WRITE_COUNT: begin
        if (!master_waitrequest) begin
          write_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      base_q           <= '0;
      next_addr_q      <= '0;
      tri_count_q      <= '0;
      w_idx_q          <= '0;
      flush_pend_q     <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
      done_out         <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      next_addr_q      <= next_addr_d;
      tri_count_q      <= tri_count_d;
      w_idx_q          <= w_idx_d;
      flush_pend_q     <= flush_pend_d;
      master_write     <= write_d;
      master_address   <= address_d;
      master_writedata <= writedata_d;
      done_out         <= done_d;
    end
  end

  // Triangle payload holding register: pure data, loaded on the handshake.
  always_ff @(posedge clock) begin
    if (load_buf) begin
      tri_buf <= vertex_in;
    end
  end

endmodule
